// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared state encoding, condition codes and default widths
// for the core sequencer and its watchdog.
package core_seq_pkg;

   // Sequencer states (3-bit encoding)
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STORE  = 3'd1,
      ST_TRANS  = 3'd2,
      ST_PROC   = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

   // Condition codes presented to mem_ctrl
   localparam logic [2:0] CC_IDLE  = 3'b000;
   localparam logic [2:0] CC_STORE = 3'b100;
   localparam logic [2:0] CC_TRANS = 3'b010;
   localparam logic [2:0] CC_PROC  = 3'b001;

   // Default widths and limits
   localparam int DEF_LEN_W          = 6;
   localparam int DEF_BATCH_W        = 4;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/core_seq_watchdog.sv
// core_seq_watchdog: clearable, enable-gated cycle counter. o_tc flags the
// cycle whose count update reaches LIMIT-1. A clear in an enabled cycle
// counts that cycle as the first one of the new phase.
module core_seq_watchdog #(
   parameter int LIMIT = 1024,
   parameter int CNT_W = $clog2(LIMIT) + 1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tc
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;

   // Next count: restart on clear, advance while enabled, hold otherwise
   always_comb begin
      w_count_next = r_count;
      if (i_clear) begin
         w_count_next = i_en ? CNT_W'(1) : '0;
      end else if (i_en) begin
         w_count_next = r_count + CNT_W'(1);
      end
   end

   assign o_tc = i_en && (w_count_next == CNT_W'(LIMIT - 1));

   // Counter register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: job sequencer driving the mem_ctrl condition-code bus
// through STORE -> (TRANS -> PROC) x batches -> FINISH -> IDLE.
// Optional per-phase watchdog enabled by defining CC_WATCHDOG_EN.
module core_seq_ctrl
   import core_seq_pkg::*;
#(
   parameter int LEN_W          = DEF_LEN_W,
   parameter int BATCH_W        = DEF_BATCH_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic               cc_clk,
   input  logic               cc_reset,
   input  logic               cc_start,
   input  logic [LEN_W-1:0]   cc_length,
   input  logic [BATCH_W-1:0] cc_batches,
   input  logic               mc_done,
   input  logic               mc_data_done,
   input  logic               pu_done,
   output logic [2:0]         cc_data_contition,
   output logic [LEN_W-1:0]   cc_data_length,
   output logic               pu_start,
   output logic               cc_busy,
   output logic               cc_finished,
   output logic               cc_error,
   output logic [BATCH_W-1:0] cc_batch_left
);

   state_t             r_state;
   logic [2:0]         r_code;
   logic [LEN_W-1:0]   r_length;
   logic [BATCH_W-1:0] r_batch_left;
   logic               r_pu_start;
   logic               r_busy;
   logic               r_finished;
   logic               w_timeout;

`ifdef CC_WATCHDOG_EN
   state_t r_prev_state;
   logic   r_error;
   logic   w_wd_en;
   logic   w_wd_clear;

   assign w_wd_en    = (r_state == ST_STORE) || (r_state == ST_TRANS) || (r_state == ST_PROC);
   assign w_wd_clear = (r_state != r_prev_state);

   // Remember last cycle's state so a state change restarts the watchdog
   always_ff @(posedge cc_clk) begin
      if (cc_reset) begin
         r_prev_state <= ST_IDLE;
      end else begin
         r_prev_state <= r_state;
      end
   end

   core_seq_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk   (cc_clk),
      .i_reset (cc_reset),
      .i_clear (w_wd_clear),
      .i_en    (w_wd_en),
      .o_tc    (w_timeout)
   );

   assign cc_error = r_error;
`else
   assign w_timeout = 1'b0;
   assign cc_error  = 1'b0;
`endif

   // Main sequencer FSM with registered outputs
   always_ff @(posedge cc_clk) begin
      if (cc_reset) begin
         r_state      <= ST_IDLE;
         r_code       <= CC_IDLE;
         r_length     <= '0;
         r_batch_left <= '0;
         r_pu_start   <= 1'b0;
         r_busy       <= 1'b0;
         r_finished   <= 1'b0;
`ifdef CC_WATCHDOG_EN
         r_error      <= 1'b0;
`endif
      end else begin
         r_pu_start <= 1'b0;
         r_finished <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cc_start) begin
                  r_length     <= cc_length;
                  r_batch_left <= (cc_batches == '0) ? BATCH_W'(1) : cc_batches;
                  r_state      <= ST_STORE;
                  r_code       <= CC_STORE;
                  r_busy       <= 1'b1;
`ifdef CC_WATCHDOG_EN
                  r_error      <= 1'b0;
`endif
               end
            end
            ST_STORE: begin
               if (mc_done) begin
                  r_state <= ST_TRANS;
                  r_code  <= CC_TRANS;
               end
            end
            ST_TRANS: begin
               // lone mc_done pulses are per-word strobes
               if (mc_done && mc_data_done) begin
                  r_state    <= ST_PROC;
                  r_code     <= CC_PROC;
                  r_pu_start <= 1'b1;
               end
            end
            ST_PROC: begin
               if (pu_done) begin
                  if (r_batch_left > BATCH_W'(1)) begin
                     r_batch_left <= r_batch_left - BATCH_W'(1);
                     r_state      <= ST_TRANS;
                     r_code       <= CC_TRANS;
                  end else begin
                     r_batch_left <= '0;
                     r_state      <= ST_FINISH;
                     r_code       <= CC_IDLE;
                     r_finished   <= 1'b1;
                  end
               end
            end
            ST_FINISH: begin
               r_state <= ST_IDLE;
               r_code  <= CC_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_code  <= CC_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // a stalled phase aborts the job without a completion pulse
         if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_code     <= CC_IDLE;
            r_busy     <= 1'b0;
            r_pu_start <= 1'b0;
            r_finished <= 1'b0;
`ifdef CC_WATCHDOG_EN
            r_error    <= 1'b1;
`endif
         end
      end
   end

   assign cc_data_contition = r_code;
   assign cc_data_length    = r_length;
   assign pu_start          = r_pu_start;
   assign cc_busy           = r_busy;
   assign cc_finished       = r_finished;
   assign cc_batch_left     = r_batch_left;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed self-checking bench for core_seq_ctrl.
// The watchdog section runs only when CC_WATCHDOG_EN is defined.
module tb_core_seq_ctrl;

   localparam int LEN_W   = 6;
   localparam int BATCH_W = 4;
`ifdef CC_WATCHDOG_EN
   localparam int TO_CYC  = 16;
`else
   localparam int TO_CYC  = 1024;
`endif

   logic               cc_clk = 1'b0;
   logic               cc_reset;
   logic               cc_start;
   logic [LEN_W-1:0]   cc_length;
   logic [BATCH_W-1:0] cc_batches;
   logic               mc_done;
   logic               mc_data_done;
   logic               pu_done;
   logic [2:0]         cc_data_contition;
   logic [LEN_W-1:0]   cc_data_length;
   logic               pu_start;
   logic               cc_busy;
   logic               cc_finished;
   logic               cc_error;
   logic [BATCH_W-1:0] cc_batch_left;

   int total = 0;
   int bad   = 0;
   int n_pu  = 0;
   int n_fin = 0;

   core_seq_ctrl #(
      .LEN_W          (LEN_W),
      .BATCH_W        (BATCH_W),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .cc_clk            (cc_clk),
      .cc_reset          (cc_reset),
      .cc_start          (cc_start),
      .cc_length         (cc_length),
      .cc_batches        (cc_batches),
      .mc_done           (mc_done),
      .mc_data_done      (mc_data_done),
      .pu_done           (pu_done),
      .cc_data_contition (cc_data_contition),
      .cc_data_length    (cc_data_length),
      .pu_start          (pu_start),
      .cc_busy           (cc_busy),
      .cc_finished       (cc_finished),
      .cc_error          (cc_error),
      .cc_batch_left     (cc_batch_left)
   );

   always #5 cc_clk = ~cc_clk;

   // one active edge, then settle; pulse outputs are tallied once per cycle
   task automatic tick();
      @(posedge cc_clk);
      #1;
      if (pu_start)    n_pu++;
      if (cc_finished) n_fin++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic start_job(input logic [LEN_W-1:0] len, input logic [BATCH_W-1:0] nb);
      cc_start   = 1'b1;
      cc_length  = len;
      cc_batches = nb;
      tick();
      cc_start   = 1'b0;
   endtask

   int pu0, fin0;

   initial begin
      cc_reset = 1'b1; cc_start = 1'b0; cc_length = '0; cc_batches = '0;
      mc_done = 1'b0; mc_data_done = 1'b0; pu_done = 1'b0;
      ticks(2);
      // ---- reset state
      check("rst_code",    cc_data_contition, 3'b000);
      check("rst_busy",    cc_busy, 1'b0);
      check("rst_pustart", pu_start, 1'b0);
      check("rst_fin",     cc_finished, 1'b0);
      check("rst_err",     cc_error, 1'b0);
      check("rst_left",    cc_batch_left, 4'd0);
      check("rst_len",     cc_data_length, 6'd0);
      cc_reset = 1'b0;
      tick();
      n_pu = 0; n_fin = 0;

      // ---- single batch, stubs answer after 3 cycles
      start_job(6'd8, 4'd1);
      check("s1_store_code", cc_data_contition, 3'b100);
      check("s1_busy",       cc_busy, 1'b1);
      check("s1_len",        cc_data_length, 6'd8);
      check("s1_left",       cc_batch_left, 4'd1);
      ticks(2);
      check("s1_store_hold", cc_data_contition, 3'b100);
      mc_done = 1'b1; tick(); mc_done = 1'b0;
      check("s1_trans_code", cc_data_contition, 3'b010);
      ticks(2);
      mc_done = 1'b1; mc_data_done = 1'b1; tick(); mc_done = 1'b0; mc_data_done = 1'b0;
      check("s1_proc_code",  cc_data_contition, 3'b001);
      check("s1_pustart",    pu_start, 1'b1);
      tick();
      check("s1_pustart_drop", pu_start, 1'b0);
      tick();
      pu_done = 1'b1; tick(); pu_done = 1'b0;
      check("s1_fin_code",   cc_data_contition, 3'b000);
      check("s1_fin_pulse",  cc_finished, 1'b1);
      check("s1_fin_busy",   cc_busy, 1'b1);
      check("s1_fin_left",   cc_batch_left, 4'd0);
      tick();
      check("s1_idle_busy",  cc_busy, 1'b0);
      check("s1_fin_drop",   cc_finished, 1'b0);
      check("s1_n_pu",       n_pu, 1);
      check("s1_n_fin",      n_fin, 1);

      // ---- three batches
      n_pu = 0; n_fin = 0;
      start_job(6'd5, 4'd3);
      check("b3_left_init", cc_batch_left, 4'd3);
      mc_done = 1'b1; tick(); mc_done = 1'b0;
      for (int b = 0; b < 3; b++) begin
         check("b3_trans_code", cc_data_contition, 3'b010);
         tick();
         mc_done = 1'b1; mc_data_done = 1'b1; tick(); mc_done = 1'b0; mc_data_done = 1'b0;
         check("b3_proc_code", cc_data_contition, 3'b001);
         check("b3_left",      cc_batch_left, 32'(3 - b));
         tick();
         pu_done = 1'b1; tick(); pu_done = 1'b0;
      end
      check("b3_fin_code", cc_data_contition, 3'b000);
      check("b3_fin_left", cc_batch_left, 4'd0);
      tick();
      check("b3_idle",  cc_busy, 1'b0);
      check("b3_n_pu",  n_pu, 3);
      check("b3_n_fin", n_fin, 1);

      // ---- start while busy, zero batches, stray inputs in STORE
      n_pu = 0; n_fin = 0;
      start_job(6'd12, 4'd0);
      check("z_left_one", cc_batch_left, 4'd1);
      start_job(6'd3, 4'd7);
      check("z_busy_start_code", cc_data_contition, 3'b100);
      check("z_busy_start_len",  cc_data_length, 6'd12);
      check("z_busy_start_left", cc_batch_left, 4'd1);
      pu_done = 1'b1; mc_data_done = 1'b1; tick(); pu_done = 1'b0; mc_data_done = 1'b0;
      check("z_stray_store", cc_data_contition, 3'b100);
      mc_done = 1'b1; tick(); mc_done = 1'b0;
      mc_done = 1'b1; mc_data_done = 1'b1; tick(); mc_done = 1'b0; mc_data_done = 1'b0;
      // pu_done in the same cycle pu_start is high
      pu_done = 1'b1; tick(); pu_done = 1'b0;
      check("z_fin_code", cc_data_contition, 3'b000);
      check("z_fin_pulse", cc_finished, 1'b1);
      ticks(2);
      check("z_no_queue", cc_busy, 1'b0);
      check("z_n_pu",  n_pu, 1);
      check("z_n_fin", n_fin, 1);

      // ---- per-word strobes in TRANS, zero length passthrough
      start_job(6'd0, 4'd1);
      check("w_len_zero", cc_data_length, 6'd0);
      mc_done = 1'b1; tick(); mc_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mc_done = 1'b1; tick(); mc_done = 1'b0; tick();
      end
      check("w_after_strobes", cc_data_contition, 3'b010);
      mc_data_done = 1'b1; tick(); mc_data_done = 1'b0;
      check("w_data_done_only", cc_data_contition, 3'b010);
      mc_done = 1'b1; mc_data_done = 1'b1; tick(); mc_done = 1'b0; mc_data_done = 1'b0;
      check("w_proc", cc_data_contition, 3'b001);
      pu_done = 1'b1; tick(); pu_done = 1'b0;
      tick();
      check("w_idle", cc_busy, 1'b0);

      // ---- mid-job reset in PROC
      start_job(6'd9, 4'd2);
      mc_done = 1'b1; tick(); mc_done = 1'b0;
      mc_done = 1'b1; mc_data_done = 1'b1; tick(); mc_done = 1'b0; mc_data_done = 1'b0;
      check("r_in_proc", cc_data_contition, 3'b001);
      fin0 = n_fin;
      cc_reset = 1'b1; tick(); cc_reset = 1'b0;
      check("r_code",    cc_data_contition, 3'b000);
      check("r_busy",    cc_busy, 1'b0);
      check("r_pustart", pu_start, 1'b0);
      check("r_fin",     cc_finished, 1'b0);
      check("r_left",    cc_batch_left, 4'd0);
      ticks(3);
      check("r_no_fin",  n_fin, fin0);
      check("r_stay_idle", cc_busy, 1'b0);

      // ---- minimum job with all handshakes held high
      pu0 = n_pu; fin0 = n_fin;
      mc_done = 1'b1; mc_data_done = 1'b1; pu_done = 1'b1;
      start_job(6'd1, 4'd1);
      check("m_store", cc_data_contition, 3'b100);
      tick();
      check("m_trans", cc_data_contition, 3'b010);
      tick();
      check("m_proc",  cc_data_contition, 3'b001);
      tick();
      check("m_fin",   cc_finished, 1'b1);
      tick();
      check("m_idle",  cc_busy, 1'b0);
      mc_done = 1'b0; mc_data_done = 1'b0; pu_done = 1'b0;
      check("m_n_pu",  n_pu - pu0, 1);
      check("m_n_fin", n_fin - fin0, 1);

`ifdef CC_WATCHDOG_EN
      // ---- watchdog timeout in PROC
      fin0 = n_fin;
      start_job(6'd4, 4'd1);
      mc_done = 1'b1; tick(); mc_done = 1'b0;
      mc_done = 1'b1; mc_data_done = 1'b1; tick(); mc_done = 1'b0; mc_data_done = 1'b0;
      ticks(TO_CYC - 2);
      check("wd_still_proc", cc_data_contition, 3'b001);
      check("wd_no_err_yet", cc_error, 1'b0);
      tick();
      check("wd_code", cc_data_contition, 3'b000);
      check("wd_err",  cc_error, 1'b1);
      check("wd_busy", cc_busy, 1'b0);
      ticks(2);
      check("wd_sticky", cc_error, 1'b1);
      check("wd_no_fin", n_fin, fin0);
      start_job(6'd4, 4'd1);
      check("wd_err_clr", cc_error, 1'b0);
      cc_reset = 1'b1; tick(); cc_reset = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
